// File: rtl/booth_ctrl_fsm_if.sv
// Handshake and strobe bundle between the Booth control FSM and its datapath.
// master = datapath/requester side, slave = controller side.
interface booth_ctrl_fsm_if;
    logic i_start;
    logic Q;
    logic Q_n;
    logic load_M;
    logic load_Q;
    logic load_Qn;
    logic load_Acc;
    logic sel_Mux;
    logic add_sub_en;
    logic c_enable;
    logic o_shift;
    logic o_busy;
    logic o_done;

    modport master (
        output i_start, Q, Q_n,
        input  load_M, load_Q, load_Qn, load_Acc, sel_Mux,
               add_sub_en, c_enable, o_shift, o_busy, o_done
    );

    modport slave (
        input  i_start, Q, Q_n,
        output load_M, load_Q, load_Qn, load_Acc, sel_Mux,
               add_sub_en, c_enable, o_shift, o_busy, o_done
    );
endinterface

// File: rtl/booth_ctrl_fsm.sv
// Control FSM for a 4-bit signed radix-2 Booth multiplier; strobes are decoded from state and {Q,Q_n}.
// Define BOOTH_SKIP_EN to fold idle (00/11) iterations into a single shifting cycle.
module booth_ctrl_fsm (
    input logic              i_clk,
    input logic              i_rst_n,
    booth_ctrl_fsm_if.slave  bus
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_ITER,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [1:0]         w_pair;

    logic w_load_m;
    logic w_load_q;
    logic w_load_qn;
    logic w_load_acc;
    logic w_sel_mux;
    logic w_add_sub;
    logic w_shift;
    logic w_done;

    // State and iteration counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    assign w_pair = {bus.Q, bus.Q_n};

    // Next-state and strobe decode
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_load_m     = 1'b0;
        w_load_q     = 1'b0;
        w_load_qn    = 1'b0;
        w_load_acc   = 1'b0;
        w_sel_mux    = 1'b0;
        w_add_sub    = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load_m     = 1'b1;
                w_load_q     = 1'b1;
                w_load_qn    = 1'b1;
                w_next_cnt   = '0;
                w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                w_load_acc   = 1'b1;
                w_next_state = S_ITER;
            end
            S_ITER: begin
                case (w_pair)
                    2'b10: begin
                        w_load_acc   = 1'b1;
                        w_sel_mux    = 1'b1;
                        w_add_sub    = 1'b1;
                        w_next_state = S_SHIFT;
                    end
                    2'b01: begin
                        w_load_acc   = 1'b1;
                        w_sel_mux    = 1'b1;
                        w_next_state = S_SHIFT;
                    end
                    default: begin
`ifdef BOOTH_SKIP_EN
                        // Nothing to add: shift now and follow the SHIFT exit rule
                        w_shift = 1'b1;
                        if (r_cnt == CNT_W'(3)) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_cnt   = r_cnt + CNT_W'(1);
                            w_next_state = S_ITER;
                        end
`else
                        w_next_state = S_SHIFT;
`endif
                    end
                endcase
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(3)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_cnt   = r_cnt + CNT_W'(1);
                    w_next_state = S_ITER;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.load_M     = w_load_m;
    assign bus.load_Q     = w_load_q;
    assign bus.load_Qn    = w_load_qn;
    assign bus.load_Acc   = w_load_acc;
    assign bus.sel_Mux    = w_sel_mux;
    assign bus.add_sub_en = w_add_sub;
    assign bus.c_enable   = w_add_sub;
    assign bus.o_shift    = w_shift;
    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_done     = w_done;

endmodule

// File: tb/tb_booth_ctrl_fsm.sv
// Self-checking bench: a Booth datapath model driven by the DUT strobes, plus a per-cycle
// expected-strobe trace derived from the multiplier bits; honours BOOTH_SKIP_EN.
module tb_booth_ctrl_fsm;

    // {load_M,load_Q,load_Qn,load_Acc,sel_Mux,add_sub_en,c_enable,o_shift,o_busy,o_done}
    localparam logic [9:0] V_IDLE  = 10'b000_0000_000;
    localparam logic [9:0] V_LOAD  = 10'b111_0000_010;
    localparam logic [9:0] V_CLEAR = 10'b000_1000_010;
    localparam logic [9:0] V_SUB   = 10'b000_1111_010;
    localparam logic [9:0] V_ADD   = 10'b000_1100_010;
    localparam logic [9:0] V_BUSY  = 10'b000_0000_010;
    localparam logic [9:0] V_SHIFT = 10'b000_0000_110;
    localparam logic [9:0] V_DONE  = 10'b000_0000_011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   a_op;
    int   b_op;
    logic [9:0] exp_q[$];
    logic prev_busy;

    booth_ctrl_fsm_if bus ();

    booth_ctrl_fsm dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: 5-bit M/ACC, 4-bit Q, appended Q-1
    logic [4:0] r_m;
    logic [4:0] r_acc;
    logic [3:0] r_q;
    logic       r_qn;
    logic signed [8:0] w_prod;

    assign bus.Q   = r_q[0];
    assign bus.Q_n = r_qn;
    assign w_prod  = {r_acc, r_q};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= 5'd0;
            r_acc <= 5'd0;
            r_q   <= 4'd0;
            r_qn  <= 1'b0;
        end else begin
            if (bus.load_M)  r_m  <= 5'(a_op);
            if (bus.load_Q)  r_q  <= 4'(b_op);
            if (bus.load_Qn) r_qn <= 1'b0;
            if (bus.load_Acc)
                r_acc <= bus.sel_Mux ? (r_acc + (bus.add_sub_en ? ~r_m : r_m) + 5'(bus.c_enable)) : 5'd0;
            if (bus.o_shift)
                {r_acc, r_q, r_qn} <= {r_acc[4], r_acc, r_q};
        end
    end

    function automatic logic [9:0] dut_vec();
        return {bus.load_M, bus.load_Q, bus.load_Qn, bus.load_Acc, bus.sel_Mux,
                bus.add_sub_en, bus.c_enable, bus.o_shift, bus.o_busy, bus.o_done};
    endfunction

    // Expected strobe sequence for one operation, from the multiplier bit pairs
    function automatic void push_trace(input int b);
        logic [3:0] bv;
        logic prev;
        logic cur;
        bv   = 4'(b);
        prev = 1'b0;
        exp_q.push_back(V_LOAD);
        exp_q.push_back(V_CLEAR);
        for (int i = 0; i < 4; i++) begin
            cur = bv[i];
            if (cur && !prev) begin
                exp_q.push_back(V_SUB);
                exp_q.push_back(V_SHIFT);
            end else if (!cur && prev) begin
                exp_q.push_back(V_ADD);
                exp_q.push_back(V_SHIFT);
            end else begin
`ifdef BOOTH_SKIP_EN
                exp_q.push_back(V_SHIFT);
`else
                exp_q.push_back(V_BUSY);
                exp_q.push_back(V_SHIFT);
`endif
            end
            prev = cur;
        end
        exp_q.push_back(V_DONE);
    endfunction

    // Model sequencing: accept only when idle, advance one entry per clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (bus.i_start) begin
            push_trace(b_op);
        end
    end

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model plus structural invariants
    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        act = dut_vec();
        exp = (!rst_n || exp_q.size() == 0) ? V_IDLE : exp_q[0];
        check_vec("cycle_strobes", act, exp);
        checks++;
        if (bus.add_sub_en !== bus.c_enable) begin
            errors++;
            $display("FAIL addsub_eq_cin: got %b/%b expected equal", bus.add_sub_en, bus.c_enable);
        end
        checks++;
        if (bus.load_Acc && bus.o_shift) begin
            errors++;
            $display("FAIL acc_shift_excl: got both 1 expected not both");
        end
        if (bus.o_done) begin
            checks++;
            if (!prev_busy) begin
                errors++;
                $display("FAIL done_after_busy: got prior busy 0 expected 1");
            end
        end
        prev_busy = bus.o_busy;
    end

    task automatic run_op(input int a, input int b, input bit pulse_busy, input int pin_lat);
        int qlen;
        int lat;
        int shifts;
        a_op = a;
        b_op = b;
        @(posedge clk); #2;
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        qlen   = exp_q.size();
        lat    = 0;
        shifts = 0;
        if (pin_lat > 0) check_int("model_len", qlen, pin_lat);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (pulse_busy && cyc == 4) bus.i_start = 1'b1;
            if (pulse_busy && cyc == 5) bus.i_start = 1'b0;
            if (bus.o_shift) shifts++;
            if (bus.o_done) begin
                lat = cyc;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no o_done expected within 40 cycles a=%0d b=%0d", a, b);
        end else begin
            check_int("latency", lat, (pin_lat > 0) ? pin_lat : qlen);
            check_int("shift_count", shifts, 4);
            check_int("product", int'(w_prod), a * b);
        end
    endtask

    initial begin
        int dones;
        int last_done;
        int shifts;
        checks      = 0;
        errors      = 0;
        a_op        = 0;
        b_op        = 0;
        prev_busy   = 1'b0;
        bus.i_start = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_vec("reset_state", dut_vec(), V_IDLE);

`ifdef BOOTH_SKIP_EN
        run_op(3, 2, 1'b0, 9);
        run_op(-8, -8, 1'b0, 8);
`else
        run_op(3, 2, 1'b0, 11);
        run_op(-8, -8, 1'b0, 11);
`endif
        run_op(7, -1, 1'b0, 0);
        run_op(-5, 3, 1'b1, 0);
        run_op(0, 0, 1'b0, 0);
        run_op(-8, 7, 1'b0, 0);
        run_op(7, 7, 1'b1, 0);
        run_op(-1, -1, 1'b0, 0);

        // i_start held high: two back-to-back operations
        a_op = 2;
        b_op = 5;
        dones = 0;
        last_done = -1;
        @(posedge clk); #2;
        bus.i_start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.load_M && last_done >= 0) check_int("b2b_gap", cyc - last_done, 2);
            if (bus.o_done) begin
                dones++;
                last_done = cyc;
            end
            if (cyc == 19) bus.i_start = 1'b0;
        end
        check_int("b2b_done_count", dones, 2);

        // Asynchronous reset during the second shift
        a_op = 5;
        b_op = -3;
        @(posedge clk); #2;
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        shifts = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (bus.o_shift) shifts++;
            if (shifts == 2) break;
        end
        check_int("reach_2nd_shift", shifts, 2);
        #1 rst_n = 1'b0;
        #1 check_vec("async_reset_outputs", dut_vec(), V_IDLE);
        @(posedge clk); #2;
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        check_int("no_done_after_abort", dones, 0);
        run_op(5, -3, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/booth_ctrl_fsm.md
BOOTH_CTRL_FSM -- requirements
Module: booth_ctrl_fsm

Interface
REQ-001 SHALL have ports: i_clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_start  in  1  request to begin one 4-bit signed multiply.
REQ-004 SHALL have ports: Q  in  1  current multiplier LSB Q0 from datapath.
REQ-005 SHALL have ports: Q_n  in  1  appended bit Q-1 from datapath.
REQ-006 SHALL have ports: load_M, load_Q, load_Qn  out  1 each  operand capture strobes.
REQ-007 SHALL have ports: load_Acc  out  1  accumulator write strobe.
REQ-008 SHALL have ports: sel_Mux  out  1  0 = write zero to accumulator, 1 = write adder result.
REQ-009 SHALL have ports: add_sub_en  out  1  1 = subtract M, 0 = add M.
REQ-010 SHALL have ports: c_enable  out  1  adder carry-in.
REQ-011 SHALL have ports: o_shift  out  1  arithmetic right shift of {ACC,Q,Q_n} this cycle.
REQ-012 SHALL have ports: o_busy  out  1  operation in progress.
REQ-013 SHALL have ports: o_done  out  1  one-cycle product-valid pulse.

Function
REQ-014 SHALL implement states IDLE, LOAD, CLEAR, ITER, SHIFT, DONE with a 2-bit iteration counter.
REQ-015 IDLE: i_start=1 -> LOAD; otherwise stay; all strobes 0.
REQ-016 LOAD (1 cycle): load_M=load_Q=load_Qn=1; counter cleared to 0; -> CLEAR.
REQ-017 CLEAR (1 cycle): load_Acc=1, sel_Mux=0; -> ITER.
REQ-018 ITER, {Q,Q_n}=10: load_Acc=1, sel_Mux=1, add_sub_en=1, c_enable=1; -> SHIFT.
REQ-019 ITER, {Q,Q_n}=01: load_Acc=1, sel_Mux=1, add_sub_en=0, c_enable=0; -> SHIFT.
REQ-020 ITER, {Q,Q_n}=00 or 11: behaviour per REQ-031/REQ-032.
REQ-021 SHIFT (1 cycle): o_shift=1; counter==3 -> DONE, else counter+1 and -> ITER.
REQ-022 DONE (1 cycle): o_done=1; -> IDLE unconditionally; i_start is not sampled in DONE.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 i_start SHALL be ignored while o_busy=1; no queuing.
REQ-025 add_sub_en and c_enable SHALL always be equal; all strobes are decoded from state and inputs, with no registered latency.
REQ-026 Exactly 4 shifts SHALL occur per operation; counter wraps 3->0 only via LOAD.

Reset
REQ-027 i_rst_n=0 SHALL force IDLE and counter=0 immediately, regardless of clock.
REQ-028 During and after reset, all outputs SHALL be 0 until i_start is accepted.
REQ-029 Reset mid-operation SHALL abort without o_done; the next i_start SHALL restart from LOAD.

Configuration
REQ-030 Macro BOOTH_SKIP_EN SHALL select the handling of idle iterations.
REQ-031 BOOTH_SKIP_EN defined: ITER with {Q,Q_n}=00/11 asserts o_shift, does not assert load_Acc, and applies the SHIFT counter/transition rule directly; the iteration takes 1 cycle.
REQ-032 BOOTH_SKIP_EN undefined: ITER with {Q,Q_n}=00/11 asserts no strobes and goes to SHIFT; every iteration takes 2 cycles; latency from i_start accept to o_done is fixed at 11 cycles.

Verification
REQ-033 Without BOOTH_SKIP_EN, model M=3, Q=0010: i_start pulse -> LOAD, CLEAR, then ITER pairs with decisions none/sub/add/none, 4 o_shift pulses; o_done 11 cycles after accept; product 6.
REQ-034 With BOOTH_SKIP_EN, same operands -> iterations take 1,2,2,1 cycles; o_done 9 cycles after accept.
REQ-035 M=-8 (11000), Q=-8 (1000) -> one subtract, three skip/idle iterations; product +64 is read from {ACC,Q}.
REQ-036 i_start held high for 20 cycles -> back-to-back operations with exactly one IDLE cycle between o_done and the next LOAD; pulses during busy are ignored.
REQ-037 i_rst_n pulled low in the 2nd SHIFT -> all outputs 0 asynchronously, no o_done; a new i_start yields a full correct operation.
REQ-038 Assertion over all runs: add_sub_en==c_enable, load_Acc and o_shift are never both 1, and o_done is never 1 with o_busy=0 in the prior cycle.
